// File: rtl/dmem_io_arbiter_pkg.sv
// Shared types and defaults for the data-memory / I/O arbiter.
package dmem_io_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCoreRd,
    StLdrRd
  } arb_state_e;

  localparam logic [31:0] PortbAddrDefault = 32'h0000_2014;
  localparam logic [31:0] PortdAddrDefault = 32'h0000_202c;

endpackage

// File: rtl/dmem_io_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter, the BRAM and the I/O registers.
// slave: arbiter side; master: requester/BRAM/I/O side.
interface dmem_io_arbiter_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 32
);
  logic                      core_read;
  logic                      core_write;
  logic [DATA_WIDTH/8-1:0]   core_byte_en;
  logic [ADDRESS_BITS-1:0]   core_address;
  logic [DATA_WIDTH-1:0]     core_wdata;
  logic                      core_ready;
  logic                      core_valid;
  logic [DATA_WIDTH-1:0]     core_rdata;

  logic                      ldr_read;
  logic                      ldr_write;
  logic [DATA_WIDTH/8-1:0]   ldr_byte_en;
  logic [ADDRESS_BITS-1:0]   ldr_address;
  logic [DATA_WIDTH-1:0]     ldr_wdata;
  logic                      ldr_ready;
  logic                      ldr_valid;
  logic [DATA_WIDTH-1:0]     ldr_rdata;

  logic                      d_mem_read;
  logic                      d_mem_write;
  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en;
  logic [ADDRESS_BITS-1:0]   d_mem_address_in;
  logic [DATA_WIDTH-1:0]     d_mem_data_in;
  logic [DATA_WIDTH-1:0]     d_mem_data_out;
  logic                      d_mem_valid;

  logic                      PORTB_write_en;
  logic                      PORTD_write_en;
  logic [7:0]                io_wdata;

  modport slave (
    input  core_read, core_write, core_byte_en, core_address, core_wdata,
    output core_ready, core_valid, core_rdata,
    input  ldr_read, ldr_write, ldr_byte_en, ldr_address, ldr_wdata,
    output ldr_ready, ldr_valid, ldr_rdata,
    output d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in,
    input  d_mem_data_out, d_mem_valid,
    output PORTB_write_en, PORTD_write_en, io_wdata
  );

  modport master (
    output core_read, core_write, core_byte_en, core_address, core_wdata,
    input  core_ready, core_valid, core_rdata,
    output ldr_read, ldr_write, ldr_byte_en, ldr_address, ldr_wdata,
    input  ldr_ready, ldr_valid, ldr_rdata,
    input  d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in,
    output d_mem_data_out, d_mem_valid,
    input  PORTB_write_en, PORTD_write_en, io_wdata
  );
endinterface

// File: rtl/dmem_io_arbiter_priority.sv
// Grant selection between core and loader.
// Optional starvation guard: DMEM_ARB_STARVE_GUARD_EN.
module dmem_arb_priority #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_idle,
  input  logic i_core_req,
  input  logic i_ldr_req,
  output logic o_grant_core,
  output logic o_grant_ldr
);

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] r_starve_cnt;
  logic [CntW-1:0] w_starve_cnt_next;
  logic            w_starved;

  assign w_starved = (r_starve_cnt >= CntW'(STARVE_LIMIT));

  // Core wins unless the loader has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    o_grant_ldr  = i_idle & i_ldr_req & (~i_core_req | w_starved);
    o_grant_core = i_idle & i_core_req & ~o_grant_ldr;
  end

  // Count core grants only while the loader is waiting; the counter cannot pass the
  // limit because the loader is forced in on the next idle grant.
  always_comb begin
    w_starve_cnt_next = r_starve_cnt;
    if (!i_ldr_req || o_grant_ldr) begin
      w_starve_cnt_next = '0;
    end else if (o_grant_core) begin
      w_starve_cnt_next = r_starve_cnt + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_cnt_next;
    end
  end
`else
  logic w_unused;
  assign w_unused = clock ^ reset;

  // Strict core priority.
  always_comb begin
    o_grant_core = i_idle & i_core_req;
    o_grant_ldr  = i_idle & i_ldr_req & ~i_core_req;
  end
`endif

endmodule

// File: rtl/dmem_io_arbiter.sv
// Arbitrates core and loader accesses onto one BRAM port and two write-only I/O
// registers (PORTB/PORTD). Writes finish in the accept cycle; reads hold the
// arbiter until the BRAM returns data.
// Optional loader starvation guard: DMEM_ARB_STARVE_GUARD_EN.
module dmem_io_arbiter
  import dmem_io_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH   = 32,
  parameter int unsigned             ADDRESS_BITS = 32,
  parameter int unsigned             STARVE_LIMIT = 8,
  parameter logic [ADDRESS_BITS-1:0] PORTB_ADDR   = ADDRESS_BITS'(PortbAddrDefault),
  parameter logic [ADDRESS_BITS-1:0] PORTD_ADDR   = ADDRESS_BITS'(PortdAddrDefault)
) (
  input logic              clock,
  input logic              reset,
  dmem_io_arbiter_if.slave bus
);

  arb_state_e r_state;
  arb_state_e w_state_next;

  logic                    w_idle;
  logic                    w_core_req;
  logic                    w_ldr_req;
  logic                    w_grant_core;
  logic                    w_grant_ldr;
  logic                    w_sel_read;
  logic                    w_sel_write;
  logic                    w_io_b;
  logic                    w_io_d;
  logic [DATA_WIDTH/8-1:0] w_sel_byte_en;
  logic [ADDRESS_BITS-1:0] w_sel_address;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;

  // Gating with reset keeps every grant low while reset is held, not just after the edge.
  assign w_idle     = reset & (r_state == StIdle);
  assign w_core_req = bus.core_read | bus.core_write;
  assign w_ldr_req  = bus.ldr_read | bus.ldr_write;

  dmem_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clock       (clock),
    .reset       (reset),
    .i_idle      (w_idle),
    .i_core_req  (w_core_req),
    .i_ldr_req   (w_ldr_req),
    .o_grant_core(w_grant_core),
    .o_grant_ldr (w_grant_ldr)
  );

  // Route the granted requester's fields; read+write together counts as a write.
  always_comb begin
    w_sel_byte_en = w_grant_ldr ? bus.ldr_byte_en : bus.core_byte_en;
    w_sel_address = w_grant_ldr ? bus.ldr_address : bus.core_address;
    w_sel_wdata   = w_grant_ldr ? bus.ldr_wdata   : bus.core_wdata;
    w_sel_write   = (w_grant_core & bus.core_write) | (w_grant_ldr & bus.ldr_write);
    w_sel_read    = (w_grant_core & bus.core_read & ~bus.core_write) |
                    (w_grant_ldr & bus.ldr_read & ~bus.ldr_write);
    w_io_b        = w_sel_write & (w_sel_address == PORTB_ADDR);
    w_io_d        = w_sel_write & (w_sel_address == PORTD_ADDR);
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: only accepted reads leave idle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_sel_read) begin
          w_state_next = w_grant_ldr ? StLdrRd : StCoreRd;
        end
      end
      StCoreRd, StLdrRd: begin
        if (bus.d_mem_valid) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs: handshakes, BRAM request and I/O strobes.
  always_comb begin
    bus.core_ready       = w_grant_core;
    bus.ldr_ready        = w_grant_ldr;
    bus.core_valid       = reset & (r_state == StCoreRd) & bus.d_mem_valid;
    bus.ldr_valid        = reset & (r_state == StLdrRd) & bus.d_mem_valid;
    bus.core_rdata       = bus.d_mem_data_out;
    bus.ldr_rdata        = bus.d_mem_data_out;
    bus.d_mem_read       = w_sel_read;
    bus.d_mem_write      = w_sel_write & ~w_io_b & ~w_io_d;
    bus.d_mem_byte_en    = w_sel_byte_en;
    bus.d_mem_address_in = w_sel_address;
    bus.d_mem_data_in    = w_sel_wdata;
    bus.PORTB_write_en   = w_io_b;
    bus.PORTD_write_en   = w_io_d;
    bus.io_wdata         = w_sel_wdata[7:0];
  end

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// Directed self-checking bench for dmem_io_arbiter with a read-data scoreboard.
// Starvation expectation follows DMEM_ARB_STARVE_GUARD_EN.
module tb_dmem_io_arbiter;

  typedef struct {
    bit          owner_ldr;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  exp_t        exp_q[$];
  logic [31:0] bram_addr;
  int          first_ldr;
  int          bad_grant;

  always #5 clock = ~clock;

  dmem_io_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_BITS(32)) bus ();

  dmem_io_arbiter #(
    .DATA_WIDTH  (32),
    .ADDRESS_BITS(32),
    .STARVE_LIMIT(8),
    .PORTB_ADDR  (32'h2014),
    .PORTD_ADDR  (32'h202c)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] bram_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
  endtask

  task automatic clear_inputs();
    bus.core_read = 1'b0;  bus.core_write = 1'b0;  bus.core_byte_en = 4'h0;
    bus.core_address = '0; bus.core_wdata = '0;
    bus.ldr_read = 1'b0;   bus.ldr_write = 1'b0;   bus.ldr_byte_en = 4'h0;
    bus.ldr_address = '0;  bus.ldr_wdata = '0;
    bus.d_mem_valid = 1'b0; bus.d_mem_data_out = '0;
  endtask

  // Called #1 after driving a read request: check the grant and push expected data.
  task automatic expect_read_grant(input string tag, input bit ldr, input logic [31:0] addr);
    check1({tag, "_core_ready"}, bus.core_ready, !ldr);
    check1({tag, "_ldr_ready"}, bus.ldr_ready, ldr);
    check1({tag, "_d_mem_read"}, bus.d_mem_read, 1'b1);
    check1({tag, "_d_mem_write"}, bus.d_mem_write, 1'b0);
    check32({tag, "_addr"}, bus.d_mem_address_in, addr);
    bram_addr = bus.d_mem_address_in;
    exp_q.push_back('{ldr, bram_fn(addr)});
  endtask

  // BRAM returns data at the current negedge; compare against the scoreboard head.
  task automatic bram_return(input string tag);
    exp_t e;
    bus.d_mem_valid    = 1'b1;
    bus.d_mem_data_out = bram_fn(bram_addr);
    #1;
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check1({tag, "_core_valid"}, bus.core_valid, !e.owner_ldr);
      check1({tag, "_ldr_valid"}, bus.ldr_valid, e.owner_ldr);
      check32({tag, "_rdata"}, e.owner_ldr ? bus.ldr_rdata : bus.core_rdata, e.data);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    bus.core_read = 1'b1;
    bus.core_address = 32'h10;
    @(negedge clock); #1;
    check1("rst_core_ready", bus.core_ready, 1'b0);
    check1("rst_ldr_ready", bus.ldr_ready, 1'b0);
    check1("rst_d_mem_read", bus.d_mem_read, 1'b0);
    check1("rst_core_valid", bus.core_valid, 1'b0);
    clear_inputs();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check1("idle_no_read", bus.d_mem_read, 1'b0);
    check1("idle_no_write", bus.d_mem_write, 1'b0);
    check1("idle_no_portb", bus.PORTB_write_en, 1'b0);

    // Core write to PORTB.
    @(negedge clock);
    bus.core_write = 1'b1; bus.core_address = 32'h2014;
    bus.core_wdata = 32'h0000_00A5; bus.core_byte_en = 4'hF;
    #1;
    check1("portb_ready", bus.core_ready, 1'b1);
    check1("portb_strobe", bus.PORTB_write_en, 1'b1);
    check1("portb_portd", bus.PORTD_write_en, 1'b0);
    check32("portb_io_wdata", 32'(bus.io_wdata), 32'hA5);
    check1("portb_no_dmem_wr", bus.d_mem_write, 1'b0);
    @(negedge clock);
    clear_inputs();
    #1;
    check1("portb_one_cycle", bus.PORTB_write_en, 1'b0);

    // Simultaneous reads: core first, loader in the following idle cycle.
    @(negedge clock);
    bus.core_read = 1'b1; bus.core_address = 32'h40;
    bus.ldr_read  = 1'b1; bus.ldr_address  = 32'h80;
    #1;
    expect_read_grant("both_rd_core", 1'b0, 32'h40);
    @(negedge clock);
    bus.core_read = 1'b0;
    #1;
    check1("core_rd_ldr_blocked", bus.ldr_ready, 1'b0);
    check1("core_rd_core_blocked", bus.core_ready, 1'b0);
    bram_return("both_rd_core_ret");
    @(negedge clock);
    bus.d_mem_valid = 1'b0;
    #1;
    expect_read_grant("both_rd_ldr", 1'b1, 32'h80);
    @(negedge clock);
    bus.ldr_read = 1'b0;
    bram_return("both_rd_ldr_ret");
    @(negedge clock);
    clear_inputs();

    // Loader write to PORTD, then core read of 0x100.
    @(negedge clock);
    bus.ldr_write = 1'b1; bus.ldr_address = 32'h202c; bus.ldr_wdata = 32'h5A;
    #1;
    check1("portd_ldr_ready", bus.ldr_ready, 1'b1);
    check1("portd_strobe", bus.PORTD_write_en, 1'b1);
    check1("portd_portb", bus.PORTB_write_en, 1'b0);
    check32("portd_io_wdata", 32'(bus.io_wdata), 32'h5A);
    check1("portd_no_dmem_wr", bus.d_mem_write, 1'b0);
    @(negedge clock);
    clear_inputs();
    bus.core_read = 1'b1; bus.core_address = 32'h100;
    #1;
    check1("portd_one_cycle", bus.PORTD_write_en, 1'b0);
    expect_read_grant("rd_0100", 1'b0, 32'h100);
    @(negedge clock);
    bus.core_read = 1'b0;
    bram_return("rd_0100_ret");
    @(negedge clock);
    clear_inputs();

    // Read+write together is a write and stays idle.
    @(negedge clock);
    bus.core_read = 1'b1; bus.core_write = 1'b1; bus.core_address = 32'h300;
    bus.core_wdata = 32'h1234_5678; bus.core_byte_en = 4'h3;
    #1;
    check1("rw_is_write", bus.d_mem_write, 1'b1);
    check1("rw_not_read", bus.d_mem_read, 1'b0);
    check32("rw_wdata", bus.d_mem_data_in, 32'h1234_5678);
    check32("rw_byte_en", 32'(bus.d_mem_byte_en), 32'h3);
    @(negedge clock);
    bus.core_write = 1'b0; bus.core_address = 32'h2014;
    #1;
    check1("io_read_no_strobe", bus.PORTB_write_en, 1'b0);
    expect_read_grant("io_read_fwd", 1'b0, 32'h2014);
    @(negedge clock);
    bus.core_read = 1'b0;
    bram_return("io_read_ret");
    @(negedge clock);
    clear_inputs();

    // Core write every cycle with a loader write pending.
    @(negedge clock);
    first_ldr = 0;
    bad_grant = 0;
    bus.ldr_write = 1'b1; bus.ldr_address = 32'h500; bus.ldr_wdata = 32'h77;
    for (int i = 1; i <= 12; i++) begin
      bus.core_write = 1'b1;
      bus.core_address = 32'h600 + 32'(i * 4);
      #1;
      if (bus.ldr_ready && first_ldr == 0) first_ldr = i;
      if ((bus.core_ready ^ bus.ldr_ready) !== 1'b1) bad_grant++;
      @(negedge clock);
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    check32("starve_first_ldr", 32'(first_ldr), 32'd9);
`else
    check32("starve_first_ldr", 32'(first_ldr), 32'd0);
`endif
    check32("starve_one_grant", 32'(bad_grant), 32'd0);
    clear_inputs();

    // Reset during a core read abandons it.
    @(negedge clock);
    bus.core_read = 1'b1; bus.core_address = 32'h44;
    #1;
    expect_read_grant("rst_rd", 1'b0, 32'h44);
    @(negedge clock);
    reset = 1'b0;
    bus.d_mem_valid = 1'b1; bus.d_mem_data_out = 32'hDEAD_BEEF;
    #1;
    check1("rst_rd_core_valid", bus.core_valid, 1'b0);
    check1("rst_rd_core_ready", bus.core_ready, 1'b0);
    check1("rst_rd_d_mem_read", bus.d_mem_read, 1'b0);
    check1("rst_rd_ldr_valid", bus.ldr_valid, 1'b0);
    exp_q.delete();
    @(negedge clock);
    bus.core_read = 1'b0;
    reset = 1'b1;
    #1;
    check1("rst_rel_no_valid0", bus.core_valid, 1'b0);
    @(negedge clock); #1;
    check1("rst_rel_no_valid1", bus.core_valid, 1'b0);
    clear_inputs();

    check32("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
